// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store unit: one op per EX handshake, run on a variable-latency
// data bus with a cycle timeout; returns the loaded word plus the addressed byte lane.
module mem_load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_word,
  output logic [7:0]            rsp_byte,
  output logic [1:0]            rsp_err,
  output logic                  stall
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic                  we_q;
  logic                  byte_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [7:0]            timer;
  logic                  misaligned;
  logic [7:0]            lane;

  assign misaligned = ~req_byte & (req_addr[1:0] != 2'b00);
  assign lane       = mem_rdata[8*addr_q[1:0] +: 8];

  // Bus outputs decode straight from state so an async reset drops them at once.
  assign req_ready = (state == IDLE);
  assign stall     = ~req_ready;
  assign mem_req   = (state == WAIT_MEM);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
  assign mem_be    = !mem_req ? 4'b0000 :
                     (byte_q & we_q) ? (4'b0001 << addr_q[1:0]) : 4'b1111;
  assign rsp_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      timer    <= '0;
      rsp_word <= '0;
      rsp_byte <= '0;
      rsp_err  <= 2'b00;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          byte_q  <= req_byte;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          if (misaligned) begin
            state    <= DONE;
            rsp_err  <= 2'b01;
            rsp_word <= '0;
            rsp_byte <= '0;
          end else begin
            state <= WAIT_MEM;
            timer <= '0;
          end
        end
        WAIT_MEM: begin
          // An ack on the limit cycle still counts as a normal completion.
          if (mem_ack) begin
            state    <= DONE;
            rsp_err  <= 2'b00;
            rsp_word <= we_q ? 32'h0 : mem_rdata;
            rsp_byte <= we_q ? 8'h0 : lane;
          end else if (timer == TMO_LAST) begin
            state    <= DONE;
            rsp_err  <= 2'b10;
            rsp_word <= '0;
            rsp_byte <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
